x_uart_cmd: RTL and testbench
=============================

Name: x_uart_cmd

Overview:
- Byte-level command decoder directly downstream of the UART receiver.
- Consumes received bytes (valid pulse plus data) and decodes a 1- or 2-byte command protocol.
- Drives a simple register write/read bus and emits a response byte for the UART transmitter over a valid/ready handshake.
- Counts protocol errors: unknown opcodes, overruns and inter-byte timeouts.

Parameters:
- p_timeout, 4096: max i_clk cycles to wait for a write payload byte after the command byte.
- p_echo, 8'hA5: response byte returned by the PING command.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset, asynchronous, active-high
- i_valid  input  1  one-cycle pulse: received byte on i_data
- i_data  input  8  received byte
- o_wr_en  output  1  one-cycle register write strobe
- o_wr_addr  output  4  write address
- o_wr_data  output  8  write data
- o_rd_en  output  1  one-cycle register read strobe
- o_rd_addr  output  4  read address
- i_rd_data  input  8  read data, valid the cycle after o_rd_en
- o_tx_valid  output  1  response byte available
- o_tx_data  output  8  response byte
- i_tx_ready  input  1  transmitter accepts byte when high with o_tx_valid
- o_err_count  output  8  saturating protocol error counter

Behaviour:
- Reset (async, i_rst=1): state IDLE; all outputs 0; timer 0; address/data registers 0.
- Command byte format: [7:4] opcode, [3:0] addr.
  - Opcode 0x1 WRITE: followed by one payload byte.
  - Opcode 0x2 READ: no payload.
  - Opcode 0x3 PING: no payload; addr ignored.
  - Any other opcode: error.
- States: IDLE, WDATA, RD, CAP, RESP.
- IDLE, on i_valid:
  - WRITE: latch addr, clear timer, go to WDATA.
  - READ: latch addr, go to RD.
  - PING: load o_tx_data=p_echo, go to RESP.
  - Other opcode: err_count+1, stay in IDLE.
- WDATA:
  - Timer increments every cycle.
  - On i_valid: latch byte; o_wr_en=1 with o_wr_addr/o_wr_data on the next cycle, exactly one cycle; return to IDLE.
  - Latency: payload i_valid in cycle N gives o_wr_en in cycle N+1.
  - If timer reaches p_timeout-1 with no i_valid: err_count+1, return to IDLE, no write.
  - Timeout and i_valid in the same cycle: the byte wins, write occurs, no error.
- RD:
  - o_rd_en=1 and o_rd_addr valid for exactly this one cycle, i.e. cycle N+1 after the command i_valid in cycle N.
  - Go to CAP.
- CAP:
  - Sample i_rd_data into o_tx_data (cycle N+2).
  - Go to RESP.
  - o_tx_valid rises in cycle N+3.
- RESP:
  - o_tx_valid=1 and o_tx_data stable until the cycle where o_tx_valid & i_tx_ready.
  - After the handshake: o_tx_valid=0 the next cycle; state IDLE.
- Overrun: i_valid while in RD, CAP or RESP → byte dropped, err_count+1, state unaffected. This includes the handshake cycle; a new command is accepted only from the next cycle onward.
- o_wr_en, o_rd_en and o_tx_valid are registered outputs, never combinational from inputs.
- o_wr_addr/o_wr_data/o_rd_addr hold their last values when strobes are low.
- err_count saturates at 8'hFF; it never wraps.
- Only one error increment occurs per cycle; error sources are mutually exclusive by state.
- Timer width is $clog2(p_timeout+1); the timer is held at 0 outside WDATA.
- Reset asserted mid-operation: immediately IDLE, strobes and o_tx_valid drop, err_count clears; a pending write is discarded.

Test Plan:
- WRITE: i_valid 8'h15 then, 10 cycles later, 8'h3C → one-cycle o_wr_en with o_wr_addr=5, o_wr_data=8'h3C, one cycle after the second i_valid; err_count=0.
- READ: 8'h27 with i_rd_data=8'h9E in the cycle after o_rd_en → o_rd_en pulse with addr 7 at N+1; o_tx_valid from N+3 with o_tx_data=8'h9E; hold i_tx_ready=0 for 5 cycles → data stable; ready=1 → valid drops the next cycle.
- PING + unknown opcode: 8'h30 → o_tx_valid with 8'hA5. Then 8'hF0 → no strobes, err_count=1.
- Timeout: 8'h12 then silence for p_timeout cycles → no o_wr_en, err_count=1, IDLE. Repeat with the payload arriving on exactly the timeout cycle → write occurs, err_count unchanged.
- Overrun/saturation: send 8'h30 with i_tx_ready=0, then 300 more bytes → err_count stops at 8'hFF; response stays 8'hA5 until accepted.
- Reset mid-WDATA and mid-RESP: o_tx_valid, o_wr_en and err_count go to 0 immediately. The next WRITE command completes normally.

Source files
------------

// File: rtl/x_uart_cmd_if.sv
// Byte/command bus between the UART byte stream, the register file and the
// response transmitter. The slave side is the command decoder.
interface x_uart_cmd_if;
    logic       valid;
    logic [7:0] data;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic [7:0] err_count;

    modport slave (
        input  valid, data, rd_data, tx_ready,
        output wr_en, wr_addr, wr_data, rd_en, rd_addr, tx_valid, tx_data, err_count
    );

    modport master (
        output valid, data, rd_data, tx_ready,
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr, tx_valid, tx_data, err_count
    );
endinterface

// File: rtl/x_uart_cmd.sv
// Byte-level command decoder behind the UART receiver: 1/2-byte WRITE, READ and
// PING commands, a register bus, a response byte and a protocol error counter.
module x_uart_cmd #(
    parameter int         p_timeout = 4096,
    parameter logic [7:0] p_echo    = 8'hA5
) (
    input  logic         i_clk,
    input  logic         i_rst,
    x_uart_cmd_if.slave  bus
);

    localparam int timer_w = $clog2(p_timeout + 1);
    localparam logic [timer_w-1:0] timer_last = timer_w'(p_timeout - 1);

    localparam logic [2:0] st_idle  = 3'd0;
    localparam logic [2:0] st_wdata = 3'd1;
    localparam logic [2:0] st_rd    = 3'd2;
    localparam logic [2:0] st_cap   = 3'd3;
    localparam logic [2:0] st_resp  = 3'd4;

    localparam logic [3:0] op_write = 4'h1;
    localparam logic [3:0] op_read  = 4'h2;
    localparam logic [3:0] op_ping  = 4'h3;

    logic [2:0]         state;
    logic [timer_w-1:0] timer;
    logic [3:0]         addr;
    logic [3:0]         opcode;
    logic               err_inc;

    assign opcode = bus.data[7:4];

    // Error sources are exclusive by state, so at most one increment per cycle.
    always_comb begin
        err_inc = 1'b0;
        case (state)
            st_idle:  err_inc = bus.valid && !(opcode inside {op_write, op_read, op_ping});
            st_wdata: err_inc = !bus.valid && (timer == timer_last);
            st_rd, st_cap, st_resp: err_inc = bus.valid;
            default:  err_inc = 1'b0;
        endcase
    end

    // NOTE: all state and outputs use non-blocking assignments so every
    // register samples the pre-edge values; strobes default low each cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= st_idle;
            timer         <= '0;
            addr          <= '0;
            bus.wr_en     <= 1'b0;
            bus.wr_addr   <= '0;
            bus.wr_data   <= '0;
            bus.rd_en     <= 1'b0;
            bus.rd_addr   <= '0;
            bus.tx_valid  <= 1'b0;
            bus.tx_data   <= '0;
            bus.err_count <= '0;
        end else begin
            bus.wr_en <= 1'b0;
            bus.rd_en <= 1'b0;

            if (err_inc && bus.err_count != 8'hFF)
                bus.err_count <= bus.err_count + 8'd1;

            case (state)
                st_idle: begin
                    timer <= '0;
                    if (bus.valid) begin
                        case (opcode)
                            op_write: begin
                                addr  <= bus.data[3:0];
                                state <= st_wdata;
                            end
                            op_read: begin
                                addr        <= bus.data[3:0];
                                bus.rd_en   <= 1'b1;
                                bus.rd_addr <= bus.data[3:0];
                                state       <= st_rd;
                            end
                            op_ping: begin
                                bus.tx_data  <= p_echo;
                                bus.tx_valid <= 1'b1;
                                state        <= st_resp;
                            end
                            default: ;
                        endcase
                    end
                end

                // A payload landing on the final timer cycle still wins.
                st_wdata: begin
                    if (bus.valid) begin
                        bus.wr_en   <= 1'b1;
                        bus.wr_addr <= addr;
                        bus.wr_data <= bus.data;
                        timer       <= '0;
                        state       <= st_idle;
                    end else if (timer == timer_last) begin
                        timer <= '0;
                        state <= st_idle;
                    end else begin
                        timer <= timer + timer_w'(1);
                    end
                end

                st_rd: state <= st_cap;

                st_cap: begin
                    bus.tx_data  <= bus.rd_data;
                    bus.tx_valid <= 1'b1;
                    state        <= st_resp;
                end

                st_resp: begin
                    if (bus.tx_valid && bus.tx_ready) begin
                        bus.tx_valid <= 1'b0;
                        state        <= st_idle;
                    end
                end

                default: begin
                    timer <= '0;
                    state <= st_idle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_x_uart_cmd.sv
// Directed self-checking bench for x_uart_cmd: write, read, ping, errors,
// timeout boundary, overrun saturation and asynchronous reset.
module tb_x_uart_cmd;

    localparam int         timeout = 4096;
    localparam logic [7:0] echo    = 8'hA5;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    x_uart_cmd_if bus ();

    x_uart_cmd #(
        .p_timeout (timeout),
        .p_echo    (echo)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, need done");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; the byte is captured by the next rising edge and
    // the task returns at the following falling edge (first cycle after capture).
    task automatic send(input logic [7:0] b);
        bus.valid = 1'b1;
        bus.data  = b;
        @(negedge clk);
        bus.valid = 1'b0;
        bus.data  = 8'h00;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int wr_seen;

        rst          = 1'b1;
        bus.valid    = 1'b0;
        bus.data     = 8'h00;
        bus.rd_data  = 8'h00;
        bus.tx_ready = 1'b0;
        #1;
        check("rst_wr_en",    32'(bus.wr_en),     32'd0);
        check("rst_rd_en",    32'(bus.rd_en),     32'd0);
        check("rst_tx_valid", 32'(bus.tx_valid),  32'd0);
        check("rst_tx_data",  32'(bus.tx_data),   32'd0);
        check("rst_wr_addr",  32'(bus.wr_addr),   32'd0);
        check("rst_wr_data",  32'(bus.wr_data),   32'd0);
        check("rst_rd_addr",  32'(bus.rd_addr),   32'd0);
        check("rst_err",      32'(bus.err_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // WRITE 0x15 then payload 0x3C ten cycles later
        send(8'h15);
        check("wr_no_early_strobe", 32'(bus.wr_en), 32'd0);
        wait_cycles(9);
        send(8'h3C);
        check("wr_en",   32'(bus.wr_en),   32'd1);
        check("wr_addr", 32'(bus.wr_addr), 32'd5);
        check("wr_data", 32'(bus.wr_data), 32'h3C);
        @(negedge clk);
        check("wr_en_one_cycle", 32'(bus.wr_en),     32'd0);
        check("wr_addr_hold",    32'(bus.wr_addr),   32'd5);
        check("wr_err",          32'(bus.err_count), 32'd0);

        // READ 0x27, read data presented only in the cycle after rd_en
        send(8'h27);
        check("rd_en",          32'(bus.rd_en),    32'd1);
        check("rd_addr",        32'(bus.rd_addr),  32'd7);
        check("rd_valid_early", 32'(bus.tx_valid), 32'd0);
        @(negedge clk);
        check("rd_en_one_cycle", 32'(bus.rd_en),    32'd0);
        check("rd_cap_valid",    32'(bus.tx_valid), 32'd0);
        bus.rd_data = 8'h9E;
        @(negedge clk);
        bus.rd_data = 8'h11;
        check("rd_tx_valid", 32'(bus.tx_valid), 32'd1);
        check("rd_tx_data",  32'(bus.tx_data),  32'h9E);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rd_hold_valid", 32'(bus.tx_valid), 32'd1);
            check("rd_hold_data",  32'(bus.tx_data),  32'h9E);
        end
        bus.tx_ready = 1'b1;
        @(negedge clk);
        bus.tx_ready = 1'b0;
        check("rd_valid_drop",   32'(bus.tx_valid),  32'd0);
        check("rd_wr_addr_hold", 32'(bus.wr_addr),   32'd5);
        check("rd_addr_hold",    32'(bus.rd_addr),   32'd7);
        check("rd_err",          32'(bus.err_count), 32'd0);

        // PING, then a READ command landing on the handshake cycle is an overrun
        send(8'h30);
        check("ping_valid", 32'(bus.tx_valid), 32'd1);
        check("ping_data",  32'(bus.tx_data),  32'hA5);
        bus.tx_ready = 1'b1;
        send(8'h21);
        bus.tx_ready = 1'b0;
        check("hs_valid_drop",  32'(bus.tx_valid),  32'd0);
        check("hs_cmd_dropped", 32'(bus.rd_en),     32'd0);
        check("hs_overrun_err", 32'(bus.err_count), 32'd1);

        // Unknown opcode
        send(8'hF0);
        check("unk_wr_en", 32'(bus.wr_en),     32'd0);
        check("unk_rd_en", 32'(bus.rd_en),     32'd0);
        check("unk_valid", 32'(bus.tx_valid),  32'd0);
        check("unk_err",   32'(bus.err_count), 32'd2);

        // Timeout: WRITE 0x12 and no payload
        send(8'h12);
        wr_seen = 0;
        for (int i = 0; i < timeout - 1; i++) begin
            @(negedge clk);
            if (bus.wr_en) wr_seen++;
        end
        check("to_err_before", 32'(bus.err_count), 32'd2);
        @(negedge clk);
        if (bus.wr_en) wr_seen++;
        check("to_err_after", 32'(bus.err_count), 32'd3);
        check("to_no_write",  32'(wr_seen),       32'd0);

        // Payload arriving on exactly the timeout cycle wins
        send(8'h12);
        wait_cycles(timeout - 1);
        send(8'hC4);
        check("tob_wr_en",   32'(bus.wr_en),     32'd1);
        check("tob_wr_addr", 32'(bus.wr_addr),   32'd2);
        check("tob_wr_data", 32'(bus.wr_data),   32'hC4);
        check("tob_err",     32'(bus.err_count), 32'd3);

        // Overrun and saturation while a PING response is pending
        send(8'h30);
        check("ovr_valid", 32'(bus.tx_valid), 32'd1);
        for (int i = 0; i < 251; i++) send(8'(i));
        check("ovr_err_fe", 32'(bus.err_count), 32'hFE);
        send(8'h15);
        check("ovr_err_ff", 32'(bus.err_count), 32'hFF);
        for (int i = 0; i < 48; i++) send(8'(i * 5));
        check("ovr_err_sat", 32'(bus.err_count), 32'hFF);
        check("ovr_valid_hold", 32'(bus.tx_valid), 32'd1);
        check("ovr_data_hold",  32'(bus.tx_data),  32'hA5);
        check("ovr_no_write",   32'(bus.wr_en),    32'd0);
        bus.tx_ready = 1'b1;
        @(negedge clk);
        bus.tx_ready = 1'b0;
        check("ovr_accepted", 32'(bus.tx_valid), 32'd0);

        // Reset in the middle of WDATA discards the pending write
        send(8'h15);
        wait_cycles(3);
        #2 rst = 1'b1;
        #1;
        check("rstw_err",     32'(bus.err_count), 32'd0);
        check("rstw_wr_en",   32'(bus.wr_en),     32'd0);
        check("rstw_wr_addr", 32'(bus.wr_addr),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(8'h47);
        check("rstw_idle_wr_en", 32'(bus.wr_en),     32'd0);
        check("rstw_idle_err",   32'(bus.err_count), 32'd1);

        // Reset during the write strobe drops it at once
        send(8'h16);
        send(8'hAA);
        check("rstp_wr_en_pre", 32'(bus.wr_en), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rstp_wr_en", 32'(bus.wr_en),     32'd0);
        check("rstp_err",   32'(bus.err_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of RESP
        send(8'h30);
        check("rstr_valid_pre", 32'(bus.tx_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rstr_valid", 32'(bus.tx_valid), 32'd0);
        check("rstr_data",  32'(bus.tx_data),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // A normal WRITE after reset
        send(8'h1E);
        send(8'h5A);
        check("post_wr_en",   32'(bus.wr_en),     32'd1);
        check("post_wr_addr", 32'(bus.wr_addr),   32'hE);
        check("post_wr_data", 32'(bus.wr_data),   32'h5A);
        check("post_err",     32'(bus.err_count), 32'd0);
        @(negedge clk);
        check("post_wr_en_drop", 32'(bus.wr_en), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
